// File: rtl/hba_qtr_pkg.sv
// Shared types and constants for the QTR frame scheduler.
// Channel search helper works on a fixed 8-bit mask so every channel count up to 8 shares it.
package hba_qtr_pkg;

    localparam int unsigned RES_W  = 8;
    localparam int unsigned MAX_CH = 8;
    localparam logic [RES_W-1:0] TIMEOUT_VAL = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        SEL,
        START,
        MEAS,
        STORE,
        DONE
    } state_t;

    // Lowest set bit at index >= from; returns MAX_CH when none remains.
    function automatic logic [3:0] first_set(input logic [MAX_CH-1:0] mask, input logic [3:0] from);
        first_set = 4'(MAX_CH);
        for (int unsigned i = MAX_CH; i > 0; i--) begin
            if (mask[i-1] && ((i - 1) >= 32'(from))) first_set = 4'(i - 1);
        end
    endfunction

endpackage

// File: rtl/hba_qtr_tick.sv
// 1 ms prescaler: one-cycle o_tick every TICK_CYCLES clocks, held cleared by i_clr.
module hba_qtr_tick #(
    parameter int unsigned TICK_CYCLES = 60_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned CW = $clog2(TICK_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(TICK_CYCLES - 1));
    assign o_tick = w_wrap && !i_clr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hba_qtr_sched.sv
// Time-shares one QTR discharge engine across NUM_CH sensors, one frame per period,
// keeping a per-channel result bank with above-threshold status.
module hba_qtr_sched
    import hba_qtr_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY  = 60_000_000,
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned CH_W           = $clog2(NUM_CH),
    parameter int unsigned TICK_CYCLES    = CLK_FREQUENCY / 1000,
    parameter int unsigned TIMEOUT_CYCLES = CLK_FREQUENCY / 200
) (
    input  logic                    hba_clk,
    input  logic                    hba_reset_n,
    input  logic                    en,
    input  logic [NUM_CH-1:0]       ch_mask,
    input  logic [7:0]              period,
    input  logic [7:0]              thresh,
    output logic [CH_W-1:0]         eng_sel,
    output logic                    eng_start,
    input  logic                    eng_busy,
    input  logic                    eng_valid,
    input  logic [7:0]              eng_value,
    output logic [RES_W*NUM_CH-1:0] ch_value,
    output logic [NUM_CH-1:0]       ch_wr,
    output logic [NUM_CH-1:0]       above,
    output logic                    thresh_cross,
    output logic                    frame_done
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t            r_state;
    logic [NUM_CH-1:0] r_mask;
    logic [CH_W-1:0]   r_ch;
    logic [7:0]        r_pcnt;
    logic [WD_W-1:0]   r_wd;

    logic              w_tick;
    logic [7:0]        w_pnext;
    logic              w_frame_due;
    logic [3:0]        w_first;
    logic [3:0]        w_next;
    logic              w_first_ok;
    logic              w_next_ok;
    logic              w_meas_end;
    logic [RES_W-1:0]  w_result;
    logic              w_above;

    hba_qtr_tick #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick (
        .i_clk  (hba_clk),
        .i_rst_n(hba_reset_n),
        .i_clr  (r_state == IDLE),
        .o_tick (w_tick)
    );

    // The tick of the current cycle counts toward the due check, so frames land exactly period ticks apart.
    assign w_pnext     = (r_pcnt == 8'hFF) ? r_pcnt : r_pcnt + {7'd0, w_tick};
    assign w_frame_due = (w_pnext >= period);
    assign w_first     = first_set(MAX_CH'(ch_mask), 4'd0);
    assign w_next      = first_set(MAX_CH'(r_mask), 4'(r_ch) + 4'd1);
    assign w_first_ok  = !w_first[3];
    assign w_next_ok   = !w_next[3];
    assign w_meas_end  = eng_valid || (r_wd >= WD_W'(TIMEOUT_CYCLES));
    assign w_result    = eng_valid ? eng_value : TIMEOUT_VAL;
    assign w_above     = (w_result > thresh);

    always_ff @(posedge hba_clk or negedge hba_reset_n) begin
        if (!hba_reset_n) begin
            r_state      <= IDLE;
            r_mask       <= '0;
            r_ch         <= '0;
            r_pcnt       <= '0;
            r_wd         <= '0;
            eng_sel      <= '0;
            eng_start    <= 1'b0;
            ch_value     <= '0;
            ch_wr        <= '0;
            above        <= '0;
            thresh_cross <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            eng_start    <= 1'b0;
            ch_wr        <= '0;
            thresh_cross <= 1'b0;
            frame_done   <= 1'b0;
            r_pcnt       <= (r_state == IDLE) ? 8'd0 : w_pnext;

            case (r_state)
                IDLE, WAIT: begin
                    if (!en) begin
                        r_state <= IDLE;
                    end else if ((r_state == IDLE) || w_frame_due) begin
                        r_mask <= ch_mask;
                        r_pcnt <= '0;
                        if (w_first_ok) begin
                            r_ch    <= CH_W'(w_first);
                            eng_sel <= CH_W'(w_first);
                            r_state <= SEL;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                SEL: begin
                    if (!en) begin
                        r_state <= IDLE;
                    end else begin
                        r_state   <= START;
                        eng_start <= !eng_busy;
                    end
                end
                START: begin
                    // eng_start is registered, so a high value here means the pulse is on the wire now.
                    if (eng_start) begin
                        r_state <= MEAS;
                        r_wd    <= WD_W'(1);
                    end else if (!en) begin
                        r_state <= IDLE;
                    end else begin
                        eng_start <= !eng_busy;
                    end
                end
                MEAS: begin
                    r_wd <= r_wd + 1'b1;
                    if (w_meas_end) begin
                        ch_value[RES_W*int'(r_ch) +: RES_W] <= w_result;
                        ch_wr[r_ch]  <= 1'b1;
                        above[r_ch]  <= w_above;
                        thresh_cross <= (above[r_ch] != w_above);
                        r_state      <= STORE;
                    end
                end
                STORE: begin
                    if (!en) begin
                        r_state <= IDLE;
                    end else if (w_next_ok) begin
                        r_ch    <= CH_W'(w_next);
                        eng_sel <= CH_W'(w_next);
                        r_state <= SEL;
                    end else begin
                        frame_done <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    r_state <= WAIT;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hba_qtr_sched.sv
// Scoreboard bench for hba_qtr_sched: expected events are queued up front and a
// negedge monitor pops one per DUT event (start, store, frame done).
module tb_hba_qtr_sched;

    logic        hba_clk     = 1'b0;
    logic        hba_reset_n = 1'b0;
    logic        en          = 1'b0;
    logic [3:0]  ch_mask     = '0;
    logic [7:0]  period      = '0;
    logic [7:0]  thresh      = '0;
    logic [1:0]  eng_sel;
    logic        eng_start;
    logic        eng_busy    = 1'b0;
    logic        eng_valid   = 1'b0;
    logic [7:0]  eng_value   = '0;
    logic [31:0] ch_value;
    logic [3:0]  ch_wr;
    logic [3:0]  above;
    logic        thresh_cross;
    logic        frame_done;

    // 20 kHz clock model: tick = 20 cycles, watchdog = 100 cycles.
    hba_qtr_sched #(
        .CLK_FREQUENCY(20_000),
        .NUM_CH(4)
    ) dut (
        .hba_clk     (hba_clk),
        .hba_reset_n (hba_reset_n),
        .en          (en),
        .ch_mask     (ch_mask),
        .period      (period),
        .thresh      (thresh),
        .eng_sel     (eng_sel),
        .eng_start   (eng_start),
        .eng_busy    (eng_busy),
        .eng_valid   (eng_valid),
        .eng_value   (eng_value),
        .ch_value    (ch_value),
        .ch_wr       (ch_wr),
        .above       (above),
        .thresh_cross(thresh_cross),
        .frame_done  (frame_done)
    );

    always #5 hba_clk = ~hba_clk;

    int cyc = 0;
    always @(posedge hba_clk) cyc <= cyc + 1;

    int total    = 0;
    int bad      = 0;
    int last_cyc = 0;

    // kind: 0 = eng_start (a = channel), 1 = store (a = channel), 2 = frame_done
    typedef struct {int kind; int a; int val; int abv; int x; int dt;} ev_t;
    typedef struct {bit drop; int val; int lat;} rsp_t;
    ev_t  exp_q[$];
    rsp_t rsp_q[$];

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic void ex(input int k, input int a, input int v, input int ab, input int x, input int dt);
        ev_t e;
        e = '{k, a, v, ab, x, dt};
        exp_q.push_back(e);
    endfunction

    function automatic void rs(input int v, input int lat, input bit drop);
        rsp_t r;
        r = '{drop, v, lat};
        rsp_q.push_back(r);
    endfunction

    task automatic got(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event", kind, -1);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", kind, e.kind);
        if (e.dt >= 0) chk("event_gap", cyc - last_cyc, e.dt);
        last_cyc = cyc;
        case (kind)
            0: chk("eng_sel", int'(eng_sel), e.a);
            1: begin
                chk("ch_wr", int'(ch_wr), 1 << e.a);
                chk("ch_value", int'(ch_value[8*e.a +: 8]), e.val);
                chk("above", int'(above), e.abv);
                chk("thresh_cross", int'(thresh_cross), e.x);
            end
            default: ;
        endcase
    endtask

    // Monitor
    initial forever begin
        @(negedge hba_clk);
        if (hba_reset_n) begin
            if (eng_start) got(0);
            if (ch_wr != '0) got(1);
            if (frame_done) got(2);
        end
    end

    // Engine model: busy for lat cycles after a start, then a one-cycle valid unless dropped.
    initial begin
        int   cnt;
        rsp_t r;
        cnt = 0;
        r   = '{1'b1, 0, 4};
        forever begin
            @(negedge hba_clk);
            eng_valid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    eng_busy = 1'b0;
                    if (!r.drop) begin
                        eng_valid = 1'b1;
                        eng_value = 8'(r.val);
                    end
                end
            end else if (eng_start && hba_reset_n) begin
                if (rsp_q.size() > 0) r = rsp_q.pop_front();
                else r = '{1'b1, 0, 4};
                eng_busy = 1'b1;
                cnt = r.lat;
            end
        end
    end

    task automatic do_reset();
        en = 1'b0;
        hba_reset_n = 1'b0;
        rsp_q.delete();
        repeat (3) @(negedge hba_clk);
        hba_reset_n = 1'b1;
        @(negedge hba_clk);
    endtask

    task automatic go();
        @(negedge hba_clk);
        en = 1'b1;
        last_cyc = cyc;
    endtask

    task automatic wait_q(input int n, input int budget);
        int k;
        k = 0;
        while (exp_q.size() > n && k < budget) begin
            @(negedge hba_clk);
            #1;
            k++;
        end
        chk("pending_events", exp_q.size() > n ? exp_q.size() : n, n);
        if (exp_q.size() > n) exp_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge hba_clk);
            #1;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_eng_sel"}, int'(eng_sel), 0);
        chk({tag, "_eng_start"}, int'(eng_start), 0);
        chk({tag, "_ch_value"}, int'(ch_value), 0);
        chk({tag, "_ch_wr"}, int'(ch_wr), 0);
        chk({tag, "_above"}, int'(above), 0);
        chk({tag, "_thresh_cross"}, int'(thresh_cross), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
    endtask

    initial begin
        // Reset state
        do_reset();
        #1;
        chk_zero("reset");

        // Mask 1011, back-to-back frames, en dropped during frame 2 channel 0
        thresh = 8'h18; period = 8'd0; ch_mask = 4'b1011;
        rs('h10, 4, 0); rs('h20, 4, 0); rs('h30, 4, 0); rs('h11, 4, 0);
        ex(0, 0, 0, 0, 0, 2);  ex(1, 0, 'h10, 'b0000, 0, 5);
        ex(0, 1, 0, 0, 0, 2);  ex(1, 1, 'h20, 'b0010, 1, 5);
        ex(0, 3, 0, 0, 0, 2);  ex(1, 3, 'h30, 'b1010, 1, 5);
        ex(2, 0, 0, 0, 0, 1);
        ex(0, 0, 0, 0, 0, 3);  ex(1, 0, 'h11, 'b1010, 0, 5);
        go();
        wait_q(1, 400);
        en = 1'b0;
        wait_q(0, 100);
        idle(20);
        chk("t1_bank", int'(ch_value), 32'h3000_2011);
        chk("t1_above", int'(above), 4'b1010);

        // Watchdog on channel 2; mask change mid-frame ignored, then empty frames forever
        do_reset();
        thresh = 8'h80; period = 8'd0; ch_mask = 4'b1101;
        rs('h05, 4, 0); rs(0, 4, 1); rs('h90, 4, 0);
        ex(0, 0, 0, 0, 0, 2);  ex(1, 0, 'h05, 'b0000, 0, 5);
        ex(0, 2, 0, 0, 0, 2);  ex(1, 2, 'hFF, 'b0100, 1, 101);
        ex(0, 3, 0, 0, 0, 2);  ex(1, 3, 'h90, 'b1100, 1, 5);
        ex(2, 0, 0, 0, 0, 1);
        go();
        wait_q(6, 100);
        ch_mask = 4'b0000;
        wait_q(0, 400);
        idle(40);
        en = 1'b0;
        idle(5);

        // Threshold crossing only on the second store
        do_reset();
        thresh = 8'h40; period = 8'd0; ch_mask = 4'b0001;
        rs('h30, 4, 0); rs('h50, 4, 0); rs('h60, 4, 0);
        ex(0, 0, 0, 0, 0, 2);  ex(1, 0, 'h30, 'b0000, 0, 5);  ex(2, 0, 0, 0, 0, 1);
        ex(0, 0, 0, 0, 0, 3);  ex(1, 0, 'h50, 'b0001, 1, 5);  ex(2, 0, 0, 0, 0, 1);
        ex(0, 0, 0, 0, 0, 3);  ex(1, 0, 'h60, 'b0001, 0, 5);  ex(2, 0, 0, 0, 0, 1);
        go();
        wait_q(2, 400);
        ch_mask = 4'b0000;
        wait_q(0, 100);
        idle(20);
        en = 1'b0;

        // period = 3 ticks (60 cycles), 10-cycle engine: starts 60 cycles apart
        do_reset();
        thresh = 8'h80; period = 8'd3; ch_mask = 4'b0001;
        rs('h01, 10, 0); rs('h02, 10, 0); rs('h03, 10, 0);
        ex(0, 0, 0, 0, 0, 2);  ex(1, 0, 'h01, 0, 0, 11);  ex(2, 0, 0, 0, 0, 1);
        ex(0, 0, 0, 0, 0, 48); ex(1, 0, 'h02, 0, 0, 11);  ex(2, 0, 0, 0, 0, 1);
        ex(0, 0, 0, 0, 0, 48); ex(1, 0, 'h03, 0, 0, 11);  ex(2, 0, 0, 0, 0, 1);
        go();
        wait_q(2, 600);
        ch_mask = 4'b0000;
        wait_q(0, 100);
        idle(100);
        en = 1'b0;

        // Overrun: long frame followed at once, missed periods not replayed
        do_reset();
        thresh = 8'h80; period = 8'd3; ch_mask = 4'b0001;
        rs('h0A, 95, 0); rs('h0B, 4, 0); rs('h0C, 4, 0);
        ex(0, 0, 0, 0, 0, 2);  ex(1, 0, 'h0A, 0, 0, 96);  ex(2, 0, 0, 0, 0, 1);
        ex(0, 0, 0, 0, 0, 3);  ex(1, 0, 'h0B, 0, 0, 5);   ex(2, 0, 0, 0, 0, 1);
        ex(0, 0, 0, 0, 0, 54); ex(1, 0, 'h0C, 0, 0, 5);   ex(2, 0, 0, 0, 0, 1);
        go();
        wait_q(2, 800);
        ch_mask = 4'b0000;
        wait_q(0, 100);
        idle(100);
        en = 1'b0;

        // en dropped while channel 1 measures
        do_reset();
        thresh = 8'h80; period = 8'd0; ch_mask = 4'b0011;
        rs('h21, 6, 0); rs('h22, 6, 0);
        ex(0, 0, 0, 0, 0, 2);  ex(1, 0, 'h21, 0, 0, 7);
        ex(0, 1, 0, 0, 0, 2);  ex(1, 1, 'h22, 0, 0, 7);
        go();
        wait_q(1, 200);
        en = 1'b0;
        wait_q(0, 100);
        idle(30);
        chk("t6_eng_sel_hold", int'(eng_sel), 1);
        chk("t6_bank", int'(ch_value), 32'h0000_2221);

        // Reset pulsed mid-measurement; the late strobe is discarded
        do_reset();
        thresh = 8'h80; period = 8'd0; ch_mask = 4'b0001;
        rs('h90, 3, 0); rs('h55, 3, 0); rs('h42, 3, 0);
        ex(0, 0, 0, 0, 0, 2);  ex(1, 0, 'h90, 'b0001, 1, 4);  ex(2, 0, 0, 0, 0, 1);
        ex(0, 0, 0, 0, 0, 3);
        ex(0, 0, 0, 0, 0, 4);  ex(1, 0, 'h42, 'b0000, 0, 4);  ex(2, 0, 0, 0, 0, 1);
        go();
        wait_q(3, 200);
        @(negedge hba_clk);
        hba_reset_n = 1'b0;
        #1;
        chk_zero("midreset");
        @(negedge hba_clk);
        hba_reset_n = 1'b1;
        wait_q(2, 50);
        ch_mask = 4'b0000;
        wait_q(0, 100);
        idle(20);
        en = 1'b0;
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hba_qtr_sched.md
# hba_qtr_sched

Frame scheduler that time-shares one QTR discharge-measurement engine across `NUM_CH` reflectance sensors. Each frame it sequences the engine channel by channel in ascending index order and keeps a per-channel result bank with above-threshold status. It sits between the hba_qtr register bank, which supplies `en`, `ch_mask`, `period` and `thresh`, and a single engine plus the sensor pin mux driven by `eng_sel`.

## Interface
- `CLK_FREQUENCY`, 60_000_000, hba_clk rate in Hz.
- `NUM_CH`, 4, number of sensor channels (2..8).
- `CH_W`, $clog2(NUM_CH), width of the channel select.
- `TICK_CYCLES`, CLK_FREQUENCY/1000, length of the 1 ms period tick.
- `TIMEOUT_CYCLES`, CLK_FREQUENCY/200, 5 ms measurement watchdog.

Ports:
- `hba_clk`  in  1  the single clock.
- `hba_reset_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  scan enable.
- `ch_mask`  in  NUM_CH  channels to scan; latched at frame start.
- `period`  in  8  frame period in 1 ms ticks; 0 = back-to-back frames.
- `thresh`  in  8  threshold for the `above` status.
- `eng_sel`  out  CH_W  channel routed to the engine and pin mux.
- `eng_start`  out  1  one-cycle start pulse to the engine.
- `eng_busy`  in  1  engine measuring.
- `eng_valid`  in  1  one-cycle result strobe.
- `eng_value`  in  8  result, qualified by `eng_valid`.
- `ch_value`  out  8*NUM_CH  latest result per channel; channel i occupies bits [8i+7:8i].
- `ch_wr`  out  NUM_CH  one-cycle pulse when the corresponding `ch_value` slice is written.
- `above`  out  NUM_CH  `ch_value[i] > thresh`, registered at store time.
- `thresh_cross`  out  1  pulse when any `above` bit changes.
- `frame_done`  out  1  pulse after the last channel of a completed frame.

## Operation
- States: `IDLE`, `WAIT`, `SEL`, `START`, `MEAS`, `STORE`, `DONE`.
- `IDLE`:
  - Tick prescaler and period counter are held at 0.
  - `en`=1 → `WAIT`, and the first frame starts immediately.
- `WAIT`:
  - The period counter counts 1 ms ticks.
  - A frame starts when the count since the previous frame start is ≥ `period`.
  - At frame start: latch `ch_mask`, reset the counter, pick the lowest set bit.
  - If the latched mask is 0: no engine activity and no `frame_done`; remain in `WAIT` for the next period.
- `SEL`:
  - `eng_sel` ← current channel.
  - Held for exactly 1 cycle so the pin mux settles.
- `START`:
  - `eng_start`=1 in the first cycle with `eng_busy`=0.
  - While `eng_busy`=1, wait in `START` with `eng_start`=0.
  - Next state → `MEAS`.
- `MEAS`:
  - Wait for `eng_valid`.
  - If `TIMEOUT_CYCLES` elapse after `eng_start` with no strobe, the result is 8'hFF.
  - `eng_valid` outside `MEAS` is ignored.
- `STORE` (1 cycle):
  - Write `ch_value[ch]`; pulse `ch_wr[ch]`.
  - Update `above[ch]`; pulse `thresh_cross` if it changed.
  - Then → `SEL` with the next higher set bit of the latched mask, or → `DONE` if none remain.
- `DONE`: `frame_done`=1 for one cycle → `WAIT`.
- Overrun: if a frame lasts longer than `period`, the next frame starts on the first `WAIT` cycle. Missed periods are not queued.
- `en` falling mid-frame:
  - The current measurement completes and is stored (the engine is never aborted).
  - Then → `IDLE`, with no further starts and no `frame_done`.
- `ch_mask` changes mid-frame do not affect the current frame.
- `thresh` changes affect only subsequent stores; `above` is not re-evaluated.
- `eng_sel` holds its value outside `SEL` and changes only in `SEL`.

## Timing
- Reset values: all outputs 0, `ch_value` all 0, `above` all 0, state `IDLE`.
- `en` rising at cycle 0:
  - `SEL` at cycle 1.
  - `eng_start` at cycle 2 if `eng_busy`=0.
- `eng_valid` at cycle t:
  - `ch_value`, `ch_wr`, `above` and `thresh_cross` update at t+1.
  - Next channel's `eng_sel` changes at t+2.
  - Its `eng_start` at t+3.
- `frame_done` one cycle after the last `ch_wr`.
- Per-channel overhead: 4 cycles plus the engine time.
- Timeout store occurs `TIMEOUT_CYCLES`+1 cycles after `eng_start`.
- Reset asserted mid-operation:
  - All state clears asynchronously; a pending engine result is discarded.
  - After release the block restarts from `IDLE`.

## Structure
- Package `hba_qtr_pkg`:
  - State enum.
  - Result width (8).
  - Timeout value 8'hFF.
- Sub-module `hba_qtr_tick`: 1 ms prescaler producing a one-cycle `tick`; held cleared while the FSM is in `IDLE`.
- Top level contains the FSM, period counter, watchdog, channel-select logic and result bank.

## Test plan
- `ch_mask`=4'b1011, `period`=0, engine returns 8'h10/8'h20/8'h30 → starts on channels 0, 1, 3 only; `ch_wr` pulses 0001, 0010, 1000 in order; `frame_done` 1 cycle after the last; next frame follows at once.
- Channel 2 engine never asserts `eng_valid` → `ch_value[2]`=8'hFF exactly `TIMEOUT_CYCLES`+1 after its start; `above[2]`=1 when `thresh`=8'h80; scan continues with channel 3.
- `thresh`=8'h40; channel 0 values 8'h30, 8'h50, 8'h60 → `thresh_cross` pulses on the 2nd store only.
- `period`=3, engine time 10 cycles → frame starts 3·`TICK_CYCLES` apart; with 5 ms engine time (overrun) frames run back-to-back, with no doubled frames.
- `en` dropped while channel 1 measures → channel 1 is stored, no further `eng_start`, no `frame_done`; `ch_mask`=0 with `en`=1 → no `eng_start` and no `frame_done` ever.
- `hba_reset_n` pulsed mid-`MEAS`, with `eng_valid` arriving 2 cycles later → all outputs 0, the strobe is ignored, and the first start comes 2 cycles after release.
